// File: rtl/fc_pkg.sv
// Shared state encoding and saturating-arithmetic helpers for the fully-connected tile engine.
package fc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_IN,
        S_CLEAR,
        S_MAC,
        S_WB,
        S_FINISH
    } fc_state_e;

    localparam int WORD_BYTES = 4;
    localparam int SAT_W      = 128;

    // Clamp a wide signed value into the signed range of a w-bit word (w is constant at every call site).
    function automatic logic signed [SAT_W-1:0] sat_to(input logic signed [SAT_W-1:0] v, input int w);
        logic signed [SAT_W-1:0] one;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        one = SAT_W'(1);
        hi  = (one <<< (w - 1)) - one;
        lo  = -(one <<< (w - 1));
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_acc(input logic signed [SAT_W-1:0] v, input int acc_w);
        return sat_to(v, acc_w);
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_data(input logic signed [SAT_W-1:0] v, input int data_w);
        return sat_to(v, data_w);
    endfunction

endpackage

// File: rtl/fc_mac_lanes.sv
// Array of signed accumulators; one selected lane adds x*w per enabled cycle, saturating to ACC_W.
module fc_mac_lanes
    import fc_pkg::*;
#(
    parameter int LANES  = 10,
    parameter int DATA_W = 32,
    parameter int ACC_W  = 48,
    parameter int LW     = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          clear_i,
    input  logic                          en_i,
    input  logic [LW-1:0]                 lane_i,
    input  logic signed [DATA_W-1:0]      x_i,
    input  logic signed [DATA_W-1:0]      w_i,
    output logic [LANES-1:0][ACC_W-1:0]   acc_o
);

    logic [LANES-1:0][ACC_W-1:0] acc_q;
    logic signed [2*DATA_W-1:0]  prod;
    logic signed [ACC_W-1:0]     sum_d;

    // Full-precision product, then one saturating add into the selected lane.
    assign prod  = (2*DATA_W)'(x_i) * (2*DATA_W)'(w_i);
    assign sum_d = ACC_W'(sat_acc(SAT_W'(signed'(acc_q[lane_i])) + SAT_W'(prod), ACC_W));

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_q <= '0;
        end else if (clear_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q[lane_i] <= sum_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/fc_tile_engine.sv
// Fully-connected layer engine: streams x and W from memory, computes y = W*x one LANES-wide
// tile at a time with optional ReLU, writes y back and optionally tracks the argmax.
module fc_tile_engine
    import fc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 48,
    parameter int LANES  = 10,
    parameter int MAX_IN = 1024
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [15:0]       cfg_n_in,
    input  logic [15:0]       cfg_n_out,
    input  logic              cfg_relu,
    input  logic              cfg_argmax,
    input  logic [31:0]       cfg_in_base,
    input  logic [31:0]       cfg_w_base,
    input  logic [31:0]       cfg_out_base,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       result_index,
    output logic [DATA_W-1:0] result_max,
    output logic              mem_valid,
    output logic              mem_write,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int IW = (MAX_IN > 1) ? $clog2(MAX_IN) : 1;

    fc_state_e                 state_q;
    logic                      busy_q, done_q, err_q;
    logic [15:0]               n_in_q, n_out_q;
    logic                      relu_q, argmax_q;
    logic [31:0]               in_base_q, w_base_q, out_base_q;
    logic [15:0]               j_q, tile_q, res_idx_q;
    logic [LW-1:0]             lane_q;
    logic signed [DATA_W-1:0]  res_max_q;

    logic signed [DATA_W-1:0]  x_buf [MAX_IN];
    logic [LANES-1:0][ACC_W-1:0] acc;

    logic [31:0]               o_idx;
    logic                      last_lane, last_j, last_tile, cfg_bad, xfer;
    logic signed [ACC_W-1:0]   acc_sel, acc_relu;
    logic signed [DATA_W-1:0]  wb_val, x_cur, w_cur;

    assign o_idx     = 32'(tile_q) + 32'(lane_q);
    assign last_lane = (lane_q == LW'(LANES - 1)) || (o_idx + 32'd1 >= 32'(n_out_q));
    assign last_j    = (j_q == n_in_q - 16'd1);
    assign last_tile = (32'(tile_q) + 32'(LANES) >= 32'(n_out_q));
    assign cfg_bad   = (cfg_n_in == 16'd0) || (32'(cfg_n_in) > 32'(MAX_IN)) || (cfg_n_out == 16'd0);
    assign xfer      = mem_valid & mem_ready;

    assign acc_sel  = signed'(acc[lane_q]);
    assign acc_relu = (relu_q && acc_sel[ACC_W-1]) ? '0 : acc_sel;
    assign wb_val   = DATA_W'(sat_data(SAT_W'(acc_relu), DATA_W));
    assign x_cur    = x_buf[j_q[IW-1:0]];
    assign w_cur    = DATA_W'(signed'(mem_rdata));

    fc_mac_lanes #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .LW     (LW)
    ) u_lanes (
        .clk     (clk),
        .resetn  (resetn),
        .clear_i (state_q == S_CLEAR),
        .en_i    (state_q == S_MAC && xfer),
        .lane_i  (lane_q),
        .x_i     (x_cur),
        .w_i     (w_cur),
        .acc_o   (acc)
    );

    // NOTE: the input buffer is plain storage with no reset; every entry read is written during LOAD_IN first.
    always_ff @(posedge clk) begin
        if (state_q == S_LOAD_IN && xfer) begin
            x_buf[j_q[IW-1:0]] <= w_cur;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            n_in_q     <= '0;
            n_out_q    <= '0;
            relu_q     <= 1'b0;
            argmax_q   <= 1'b0;
            in_base_q  <= '0;
            w_base_q   <= '0;
            out_base_q <= '0;
            j_q        <= '0;
            tile_q     <= '0;
            lane_q     <= '0;
            res_idx_q  <= '0;
            res_max_q  <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: if (start) begin
                    n_in_q     <= cfg_n_in;
                    n_out_q    <= cfg_n_out;
                    relu_q     <= cfg_relu;
                    argmax_q   <= cfg_argmax;
                    in_base_q  <= cfg_in_base;
                    w_base_q   <= cfg_w_base;
                    out_base_q <= cfg_out_base;
                    j_q        <= '0;
                    tile_q     <= '0;
                    lane_q     <= '0;
                    res_idx_q  <= '0;
                    res_max_q  <= '0;
                    busy_q     <= 1'b1;
                    if (cfg_bad) begin
                        state_q <= S_FINISH;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        state_q <= S_LOAD_IN;
                    end
                end
                S_LOAD_IN: if (xfer) begin
                    j_q <= last_j ? '0 : j_q + 16'd1;
                    if (last_j) state_q <= S_CLEAR;
                end
                S_CLEAR: state_q <= S_MAC;
                // j walks the input vector; lanes of the current tile are visited inside each j.
                S_MAC: if (xfer) begin
                    if (last_lane) begin
                        lane_q <= '0;
                        j_q    <= last_j ? '0 : j_q + 16'd1;
                        if (last_j) state_q <= S_WB;
                    end else begin
                        lane_q <= lane_q + LW'(1);
                    end
                end
                S_WB: if (xfer) begin
                    // Strict greater-than keeps the lowest index on ties; output 0 always seeds the max.
                    if (argmax_q && (o_idx == 32'd0 || wb_val > res_max_q)) begin
                        res_max_q <= wb_val;
                        res_idx_q <= o_idx[15:0];
                    end
                    if (last_lane) begin
                        lane_q <= '0;
                        if (last_tile) begin
                            state_q <= S_FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            tile_q  <= tile_q + 16'(LANES);
                            state_q <= S_CLEAR;
                        end
                    end else begin
                        lane_q <= lane_q + LW'(1);
                    end
                end
                S_FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        mem_valid = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state_q)
            S_LOAD_IN: begin
                mem_valid = 1'b1;
                mem_addr  = in_base_q + 32'(WORD_BYTES) * 32'(j_q);
            end
            S_MAC: begin
                mem_valid = 1'b1;
                mem_addr  = w_base_q + 32'(WORD_BYTES) * (o_idx * 32'(n_in_q) + 32'(j_q));
            end
            S_WB: begin
                mem_valid = 1'b1;
                mem_write = 1'b1;
                mem_addr  = out_base_q + 32'(WORD_BYTES) * o_idx;
                mem_wdata = 32'(wb_val);
            end
            default: ;
        endcase
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign result_index = res_idx_q;
    assign result_max   = res_max_q;

endmodule
